// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
// Optional macro FIFO_WR_ARB_AF_THROTTLE_EN restricts arbitration to requester 0 while almost full.
module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [N_REQ-1:0]              req,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              gnt,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [$clog2(N_REQ)-1:0]      owner_id,
    output logic                          busy
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int IW1  = ID_W + 1;
    localparam int BC_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [ID_W-1:0]        owner_id_r, owner_id_s;
    logic [ID_W-1:0]        rr_ptr_r, rr_ptr_s;
    logic [BC_W-1:0]        beat_cnt_r, beat_cnt_s;

    logic [N_REQ-1:0]       arb_req_s;
    logic [ID_W-1:0]        pick_s;
    logic                   pick_vld_s;
    logic [IW1-1:0]         idx_s;
    logic                   owner_req_s;
    logic                   accept_s;
    logic                   af_cut_s;
    logic [N_REQ-1:0]       gnt_s;
    logic                   wr_en_s;
    logic [DATA_WIDTH-1:0]  wr_data_s;

`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
    // Almost-full narrows arbitration to the control channel and cuts other bursts short
    always_comb begin
        if (fifo_almost_full) begin
            arb_req_s = {{(N_REQ-1){1'b0}}, req[0]};
        end else begin
            arb_req_s = req;
        end
        af_cut_s = fifo_almost_full && (owner_id_r != {ID_W{1'b0}});
    end
`else
    logic unused_af_s;
    assign unused_af_s = fifo_almost_full;

    // Plain round-robin: almost-full has no influence
    always_comb begin
        arb_req_s = req;
        af_cut_s  = 1'b0;
    end
`endif

    // Rotating priority pick: scanning downward lets the lowest offset from rr_ptr win
    always_comb begin
        pick_vld_s = 1'b0;
        pick_s     = {ID_W{1'b0}};
        idx_s      = {IW1{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s = {1'b0, rr_ptr_r} + IW1'(i);
            if (idx_s >= IW1'(N_REQ)) begin
                idx_s = idx_s - IW1'(N_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (arb_req_s[idx_s[ID_W-1:0]]) begin
                pick_vld_s = 1'b1;
                pick_s     = idx_s[ID_W-1:0];
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    assign owner_req_s = req[owner_id_r];
    assign accept_s    = (state_r == ST_BURST) && owner_req_s && !fifo_full;

    // Next-state logic plus the combinational beat accept onto the write port
    always_comb begin
        state_s    = state_r;
        owner_id_s = owner_id_r;
        rr_ptr_s   = rr_ptr_r;
        beat_cnt_s = beat_cnt_r;
        gnt_s      = {N_REQ{1'b0}};
        wr_en_s    = 1'b0;
        wr_data_s  = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (pick_vld_s) begin
                    owner_id_s = pick_s;
                    beat_cnt_s = {BC_W{1'b0}};
                    state_s    = ST_BURST;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (accept_s) begin
                    gnt_s[owner_id_r] = 1'b1;
                    wr_en_s           = 1'b1;
                    wr_data_s         = req_data[owner_id_r*DATA_WIDTH +: DATA_WIDTH];
                    beat_cnt_s        = beat_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
                end else begin
                    beat_cnt_s        = beat_cnt_r;
                end
                if (!owner_req_s ||
                    (accept_s && ((beat_cnt_r == BC_W'(MAX_BURST - 1)) || af_cut_s))) begin
                    state_s = ST_IDLE;
                    if (owner_id_r == ID_W'(N_REQ - 1)) begin
                        rr_ptr_s = {ID_W{1'b0}};
                    end else begin
                        rr_ptr_s = owner_id_r + {{(ID_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_BURST;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, ownership, rotation pointer and beat counter registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r    <= ST_IDLE;
            owner_id_r <= {ID_W{1'b0}};
            rr_ptr_r   <= {ID_W{1'b0}};
            beat_cnt_r <= {BC_W{1'b0}};
        end else begin
            state_r    <= state_s;
            owner_id_r <= owner_id_s;
            rr_ptr_r   <= rr_ptr_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    assign gnt          = gnt_s;
    assign fifo_wr_en   = wr_en_s;
    assign fifo_wr_data = wr_data_s;
    assign owner_id     = owner_id_r;
    assign busy         = (state_r == ST_BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers emit {id, seq} words; expected writes are queued up front.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic [1:0]  owner_id;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wr_cnt   = 0;
    logic [9:0]  exp_q[$];
    logic [3:0]  gnt_q;
    logic [5:0]  seq [4];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
        .clk(clk), .arst_n(arst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .owner_id(owner_id), .busy(busy)
    );

    function automatic logic [9:0] mk(input logic [1:0] o, input logic [5:0] s);
        return {o, o, s};
    endfunction

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), seq[i]};
    endtask

    // Advance one clock; producers whose beat was accepted present their next word
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (gnt_q[i]) seq[i] = seq[i] + 6'd1;
        gnt_q = 4'd0;
        drive_data();
    endtask

    task automatic do_reset(input logic [3:0] r);
        arst_n = 1'b0;
        req = r;
        fifo_full = 1'b0;
        fifo_almost_full = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 6'd0;
        gnt_q = 4'd0;
        drive_data();
        @(posedge clk); #1;
        @(posedge clk); #1;
        arst_n = 1'b1;
    endtask

    // Scoreboard monitor: protocol sanity each cycle, pop and compare on every write
    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            n_checks++;
            if ((fifo_wr_en !== (|gnt)) || ($countones(gnt) > 1) || (fifo_wr_en && fifo_full))
                $display("FAIL protocol: gnt=%b wr_en=%b full=%b", gnt, fifo_wr_en, fifo_full);
            else n_pass++;
            if (fifo_wr_en === 1'b1) begin
                gnt_q = gnt;
                wr_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got owner=%0d data=%h required none", owner_id, fifo_wr_data);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({owner_id, fifo_wr_data} !== e || gnt !== (4'b0001 << e[9:8]))
                        $display("FAIL write: got owner=%0d data=%h gnt=%b required owner=%0d data=%h",
                                 owner_id, fifo_wr_data, gnt, e[9:8], e[7:0]);
                    else n_pass++;
                end
            end
        end
    end

    task automatic test_reset();
        arst_n = 1'b0; req = 4'hF; fifo_full = 1'b0; fifo_almost_full = 1'b0; gnt_q = 4'd0;
        for (int i = 0; i < 4; i++) seq[i] = 6'd0;
        drive_data();
        @(negedge clk);
        n_checks++;
        if ({gnt, fifo_wr_en, busy, owner_id, fifo_wr_data} !== 16'd0)
            $display("FAIL reset_outputs: got gnt=%b wr=%b busy=%b owner=%0d data=%h required all 0",
                     gnt, fifo_wr_en, busy, owner_id, fifo_wr_data);
        else n_pass++;
        @(posedge clk); #1;
        arst_n = 1'b1;
        exp_q.push_back(mk(2'd0, 6'd0));
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: got busy=%b required 0", busy); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || owner_id !== 2'd0 || fifo_wr_en !== 1'b1)
            $display("FAIL reset_first_grant: got busy=%b owner=%0d wr=%b required 1 0 1", busy, owner_id, fifo_wr_en);
        else n_pass++;
        tick();
        arst_n = 1'b0;
        #1;
        n_checks++;
        if (fifo_wr_en !== 1'b0 || gnt !== 4'd0 || busy !== 1'b0)
            $display("FAIL reset_abort: got wr=%b gnt=%b busy=%b required 0", fifo_wr_en, gnt, busy);
        else n_pass++;
        req = 4'd0;
        @(posedge clk); #1;
        arst_n = 1'b1;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL reset_queue: got %0d pending required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_burst_cap();
        logic [9:0] pat;
        pat = 10'b1111011110;
        do_reset(4'b0001);
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(2'd0, 6'(k)));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (fifo_wr_en !== pat[c]) $display("FAIL burst_cap c%0d: got wr=%b required %b", c, fifo_wr_en, pat[c]);
            else n_pass++;
            tick();
        end
        req = 4'd0;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL burst_cap_count: got %0d pending required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [1:0] ord [3];
        ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd3;
        do_reset(4'b1011);
        for (int b = 0; b < 6; b++)
            for (int k = 0; k < 4; k++) exp_q.push_back(mk(ord[b % 3], 6'((b / 3) * 4 + k)));
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== ((c % 5) != 0)) $display("FAIL rr_busy c%0d: got %b required %b", c, busy, (c % 5) != 0);
            else n_pass++;
            tick();
        end
        req = 4'd0;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL rr_count: got %0d pending required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_full_stall();
        logic [10:0] pat;
        pat = 11'b01100000110;
        do_reset(4'b0100);
        wr_cnt = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(2'd2, 6'(k)));
        for (int c = 0; c < 11; c++) begin
            fifo_full = (c >= 3 && c <= 7);
            if (c == 10) req = 4'd0;
            @(negedge clk);
            n_checks++;
            if (fifo_wr_en !== pat[c]) $display("FAIL stall c%0d: got wr=%b required %b", c, fifo_wr_en, pat[c]);
            else n_pass++;
            if (fifo_full) begin
                n_checks++;
                if (gnt !== 4'd0 || busy !== 1'b1) $display("FAIL stall_hold c%0d: got gnt=%b busy=%b required 0 1", c, gnt, busy);
                else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (wr_cnt !== 4 || exp_q.size() !== 0)
            $display("FAIL stall_total: got %0d writes required 4", wr_cnt);
        else n_pass++;
    endtask

    task automatic test_early_drop();
        logic [7:0] wpat, bpat;
        wpat = 8'b00100110;
        bpat = 8'b01101110;
        do_reset(4'b0110);
        exp_q.push_back(mk(2'd1, 6'd0));
        exp_q.push_back(mk(2'd1, 6'd1));
        exp_q.push_back(mk(2'd2, 6'd0));
        for (int c = 0; c < 8; c++) begin
            if (c == 3) req = 4'b0101;
            if (c == 6) req = 4'b0001;
            if (c == 7) req = 4'b0000;
            @(negedge clk);
            n_checks++;
            if (fifo_wr_en !== wpat[c] || busy !== bpat[c])
                $display("FAIL early_drop c%0d: got wr=%b busy=%b required %b %b", c, fifo_wr_en, busy, wpat[c], bpat[c]);
            else n_pass++;
            if (c == 5) begin
                n_checks++;
                if (owner_id !== 2'd2) $display("FAIL early_drop_owner: got %0d required 2", owner_id); else n_pass++;
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL early_drop_count: got %0d pending required 0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_throttle();
        do_reset(4'b0110);
        fifo_almost_full = 1'b1;
`ifdef FIFO_WR_ARB_AF_THROTTLE_EN
        for (int c = 0; c < 6; c++) begin
            if (c == 3) req = 4'b0111;
            if (c == 4) exp_q.push_back(mk(2'd0, 6'd0));
            if (c == 5) req = 4'b0000;
            @(negedge clk);
            n_checks++;
            if (busy !== (c == 4 || c == 5) || fifo_wr_en !== (c == 4))
                $display("FAIL throttle c%0d: got busy=%b wr=%b", c, busy, fifo_wr_en);
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (owner_id !== 2'd0) $display("FAIL throttle_owner: got %0d required 0", owner_id); else n_pass++;
            end
            tick();
        end
`else
        exp_q.push_back(mk(2'd1, 6'd0));
        for (int c = 0; c < 3; c++) begin
            if (c == 2) req = 4'b0000;
            @(negedge clk);
            n_checks++;
            if (busy !== (c != 0) || fifo_wr_en !== (c == 1))
                $display("FAIL throttle_off c%0d: got busy=%b wr=%b", c, busy, fifo_wr_en);
            else n_pass++;
            if (c == 1) begin
                n_checks++;
                if (owner_id !== 2'd1) $display("FAIL throttle_off_owner: got %0d required 1", owner_id); else n_pass++;
            end
            tick();
        end
`endif
        fifo_almost_full = 1'b0;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL throttle_count: got %0d pending required 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n = 1'b0;
        test_reset();
        test_burst_cap();
        test_round_robin();
        test_full_stall();
        test_early_drop();
        test_throttle();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
